// File: rtl/display_update_scheduler_pkg.sv
// Shared display definitions: bus widths, scheduler state encoding and the
// default stale threshold used by the frame-synchronous update scheduler.
package display_update_scheduler_pkg;

   localparam int LOC_W             = 12;
   localparam int ORIENT_W          = 4;
   localparam int STALE_FRAMES_DEF  = 60;
   localparam int FRAME_CNT_W_DEF   = 8;

   typedef enum logic [1:0] {
      ACCEPT     = 2'd0,
      COMMIT     = 2'd1,
      BLANK_WAIT = 2'd2
   } sched_state_e;

   // A fresh orientation wins; otherwise a fresh location invalidates the old one.
   function automatic logic next_orient_ready(input logic orient_full,
                                              input logic loc_full,
                                              input logic cur);
      logic res;
      if (orient_full) begin
         res = 1'b1;
      end else if (loc_full) begin
         res = 1'b0;
      end else begin
         res = cur;
      end
      return res;
   endfunction

endpackage

// File: rtl/display_update_scheduler_if.sv
// Producer handshakes and committed display outputs between the rover-data
// producers, the scheduler and the VGA writer.
interface display_update_scheduler_if;
   import display_update_scheduler_pkg::*;

   logic                loc_valid;
   logic [LOC_W-1:0]    loc_data;
   logic                loc_ready;
   logic                orient_valid;
   logic [ORIENT_W-1:0] orient_data;
   logic                orient_ready;
   logic                move_valid;
   logic [LOC_W-1:0]    move_data;
   logic                move_ready;
   logic [LOC_W-1:0]    disp_location;
   logic [ORIENT_W-1:0] disp_orientation;
   logic [LOC_W-1:0]    disp_move_command;
   logic                new_data;
   logic                orientation_ready;
   logic                stale;

   modport master (
      output loc_valid, loc_data, orient_valid, orient_data, move_valid, move_data,
      input  loc_ready, orient_ready, move_ready,
      input  disp_location, disp_orientation, disp_move_command,
      input  new_data, orientation_ready, stale
   );

   modport slave (
      input  loc_valid, loc_data, orient_valid, orient_data, move_valid, move_data,
      output loc_ready, orient_ready, move_ready,
      output disp_location, disp_orientation, disp_move_command,
      output new_data, orientation_ready, stale
   );
endinterface

// File: rtl/display_update_scheduler_update_slot.sv
// Single-entry valid/ready holding register; once full it back-pressures the
// producer until the scheduler clears it at a frame commit.
module update_slot #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         accept_en,
   input  logic         clear,
   input  logic         valid,
   input  logic [W-1:0] data_in,
   output logic         ready,
   output logic         full,
   output logic [W-1:0] data
);
   logic         full_r;
   logic [W-1:0] data_r;

   assign ready = ~reset & accept_en & ~full_r;
   assign full  = full_r;
   assign data  = data_r;

   // Capture on transfer, drop the entry when the frame commit consumes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_r <= 1'b0;
         data_r <= '0;
      end else if (clear) begin
         full_r <= 1'b0;
         data_r <= data_r;
      end else if (valid && ready) begin
         full_r <= 1'b1;
         data_r <= data_in;
      end else begin
         full_r <= full_r;
         data_r <= data_r;
      end
   end
endmodule

// File: rtl/display_update_scheduler.sv
// Buffers one update per rover-data producer and commits all of them together
// on the falling edge of vsync so the VGA writer sees a frame-stable picture.
module display_update_scheduler
   import display_update_scheduler_pkg::*;
#(
   parameter int STALE_FRAMES = STALE_FRAMES_DEF,
   parameter int FRAME_CNT_W  = FRAME_CNT_W_DEF
) (
   input  logic                        vclock,
   input  logic                        reset,
   input  logic                        vsync,
   display_update_scheduler_if.slave   bus
);
   localparam logic [FRAME_CNT_W-1:0] STALE_MAX = FRAME_CNT_W'(STALE_FRAMES);

   sched_state_e           state_r, state_next_s;
   logic                   vsync_q_r;
   logic                   edge_s, commit_s, accept_s;
   logic                   loc_full_s, orient_full_s, move_full_s;
   logic [LOC_W-1:0]       loc_slot_s, move_slot_s;
   logic [ORIENT_W-1:0]    orient_slot_s;
   logic [LOC_W-1:0]       disp_location_r, disp_move_command_r;
   logic [ORIENT_W-1:0]    disp_orientation_r;
   logic                   new_data_r, orientation_ready_r, stale_r;
   logic [FRAME_CNT_W-1:0] frame_cnt_r, frame_cnt_next_s;

   assign edge_s = vsync_q_r & ~vsync;

   update_slot #(.W(LOC_W)) u_loc_slot (
      .clk(vclock), .reset(reset), .accept_en(accept_s), .clear(commit_s),
      .valid(bus.loc_valid), .data_in(bus.loc_data), .ready(bus.loc_ready),
      .full(loc_full_s), .data(loc_slot_s));

   update_slot #(.W(ORIENT_W)) u_orient_slot (
      .clk(vclock), .reset(reset), .accept_en(accept_s), .clear(commit_s),
      .valid(bus.orient_valid), .data_in(bus.orient_data), .ready(bus.orient_ready),
      .full(orient_full_s), .data(orient_slot_s));

   update_slot #(.W(LOC_W)) u_move_slot (
      .clk(vclock), .reset(reset), .accept_en(accept_s), .clear(commit_s),
      .valid(bus.move_valid), .data_in(bus.move_data), .ready(bus.move_ready),
      .full(move_full_s), .data(move_slot_s));

   // State and vsync history registers.
   always_ff @(posedge vclock) begin
      if (reset) begin
         state_r   <= ACCEPT;
         vsync_q_r <= 1'b1;
      end else begin
         state_r   <= state_next_s;
         vsync_q_r <= vsync;
      end
   end

   // Next-state decode and per-state strobes.
   always_comb begin
      state_next_s = state_r;
      commit_s     = 1'b0;
      accept_s     = 1'b1;
      case (state_r)
         ACCEPT: begin
            if (edge_s) state_next_s = COMMIT;
            else        state_next_s = ACCEPT;
         end
         COMMIT: begin
            commit_s     = 1'b1;
            accept_s     = 1'b0;
            state_next_s = BLANK_WAIT;
         end
         BLANK_WAIT: begin
            if (vsync) state_next_s = ACCEPT;
            else       state_next_s = BLANK_WAIT;
         end
         default: begin
            state_next_s = ACCEPT;
         end
      endcase
   end

   // Frames since the last location commit, saturating at the stale threshold.
   always_comb begin
      frame_cnt_next_s = frame_cnt_r;
      if (loc_full_s) begin
         frame_cnt_next_s = '0;
      end else if (frame_cnt_r == STALE_MAX) begin
         frame_cnt_next_s = frame_cnt_r;
      end else begin
         frame_cnt_next_s = frame_cnt_r + FRAME_CNT_W'(1);
      end
   end

   // Commit full slots and refresh the writer qualifiers once per frame.
   always_ff @(posedge vclock) begin
      if (reset) begin
         disp_location_r     <= '0;
         disp_orientation_r  <= '0;
         disp_move_command_r <= '0;
         new_data_r          <= 1'b0;
         orientation_ready_r <= 1'b0;
         stale_r             <= 1'b0;
         frame_cnt_r         <= '0;
      end else if (commit_s) begin
         if (loc_full_s)    disp_location_r     <= loc_slot_s;
         if (orient_full_s) disp_orientation_r  <= orient_slot_s;
         if (move_full_s)   disp_move_command_r <= move_slot_s;
         new_data_r          <= loc_full_s;
         orientation_ready_r <= next_orient_ready(orient_full_s, loc_full_s, orientation_ready_r);
         frame_cnt_r         <= frame_cnt_next_s;
         stale_r             <= (frame_cnt_next_s == STALE_MAX);
      end
   end

   assign bus.disp_location     = disp_location_r;
   assign bus.disp_orientation  = disp_orientation_r;
   assign bus.disp_move_command = disp_move_command_r;
   assign bus.new_data          = new_data_r;
   assign bus.orientation_ready = orientation_ready_r;
   assign bus.stale             = stale_r;
endmodule

// File: tb/tb_display_update_scheduler.sv
// Directed bench for display_update_scheduler with a 3-frame stale threshold.
module tb_display_update_scheduler;
   import display_update_scheduler_pkg::*;

   logic vclock = 1'b0;
   logic reset;
   logic vsync;
   int   n_tests = 0;
   int   n_fail  = 0;

   display_update_scheduler_if bus();

   display_update_scheduler #(.STALE_FRAMES(3), .FRAME_CNT_W(8)) dut (
      .vclock(vclock), .reset(reset), .vsync(vsync), .bus(bus));

   always #5 vclock = ~vclock;

   task automatic tick();
      @(posedge vclock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_valids();
      bus.loc_valid    = 1'b0;
      bus.orient_valid = 1'b0;
      bus.move_valid   = 1'b0;
   endtask

   // Edge cycle, COMMIT cycle (readys must be low), BLANK_WAIT, back to ACCEPT.
   task automatic frame();
      vsync = 1'b0;
      tick();
      chk("commit_readys", {29'd0, bus.loc_ready, bus.orient_ready, bus.move_ready}, 32'd0);
      tick();
      vsync = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      vsync = 1'b1;
      bus.loc_valid    = 1'b1; bus.loc_data    = 12'h7FF;
      bus.orient_valid = 1'b1; bus.orient_data = 4'hF;
      bus.move_valid   = 1'b1; bus.move_data   = 12'h7FF;

      // Reset with all valids high.
      repeat (5) begin
         tick();
         chk("rst_readys", {29'd0, bus.loc_ready, bus.orient_ready, bus.move_ready}, 32'd0);
      end
      chk("rst_loc",    {20'd0, bus.disp_location}, 32'd0);
      chk("rst_orient", {28'd0, bus.disp_orientation}, 32'd0);
      chk("rst_move",   {20'd0, bus.disp_move_command}, 32'd0);
      chk("rst_quals",  {29'd0, bus.new_data, bus.orientation_ready, bus.stale}, 32'd0);
      reset = 1'b0;
      clear_valids();
      #1;
      chk("post_rst_readys", {29'd0, bus.loc_ready, bus.orient_ready, bus.move_ready}, 32'd7);

      // Location mid-frame, then manual frame with latency checks.
      bus.loc_valid = 1'b1; bus.loc_data = 12'h2A5;
      tick();
      bus.loc_valid = 1'b0;
      chk("loc_full_ready", {31'd0, bus.loc_ready}, 32'd0);
      vsync = 1'b0;
      tick();
      chk("lat_n1_loc", {20'd0, bus.disp_location}, 32'd0);
      chk("lat_n1_new", {31'd0, bus.new_data}, 32'd0);
      tick();
      chk("lat_n2_loc", {20'd0, bus.disp_location}, 32'h2A5);
      chk("lat_n2_quals", {29'd0, bus.new_data, bus.orientation_ready, bus.stale}, 32'b100);
      vsync = 1'b1;
      tick();

      // Location plus orientation in one frame, then location alone.
      bus.loc_valid = 1'b1; bus.loc_data = 12'h111;
      bus.orient_valid = 1'b1; bus.orient_data = 4'h3;
      tick();
      clear_valids();
      frame();
      chk("lo_loc", {20'd0, bus.disp_location}, 32'h111);
      chk("lo_orient", {28'd0, bus.disp_orientation}, 32'h3);
      chk("lo_quals", {29'd0, bus.new_data, bus.orientation_ready, bus.stale}, 32'b110);
      bus.loc_valid = 1'b1; bus.loc_data = 12'h122;
      tick();
      clear_valids();
      frame();
      chk("l_only_loc", {20'd0, bus.disp_location}, 32'h122);
      chk("l_only_orient", {28'd0, bus.disp_orientation}, 32'h3);
      chk("l_only_quals", {29'd0, bus.new_data, bus.orientation_ready, bus.stale}, 32'b100);

      // Backpressure: second location held until after the commit.
      bus.loc_valid = 1'b1; bus.loc_data = 12'h0F0;
      tick();
      bus.loc_data = 12'h0AA;
      chk("bp_ready", {31'd0, bus.loc_ready}, 32'd0);
      tick();
      chk("bp_ready_hold", {31'd0, bus.loc_ready}, 32'd0);
      frame();
      bus.loc_valid = 1'b0;
      chk("bp_loc_first", {20'd0, bus.disp_location}, 32'h0F0);
      chk("bp_slot_refilled", {31'd0, bus.loc_ready}, 32'd0);
      frame();
      chk("bp_loc_second", {20'd0, bus.disp_location}, 32'h0AA);
      chk("bp_new", {31'd0, bus.new_data}, 32'd1);

      // Move command valid only on the edge cycle.
      bus.move_valid = 1'b1; bus.move_data = 12'h800;
      vsync = 1'b0;
      #1;
      chk("edge_move_ready", {31'd0, bus.move_ready}, 32'd1);
      tick();
      bus.move_valid = 1'b0;
      chk("mv_commit_readys", {29'd0, bus.loc_ready, bus.orient_ready, bus.move_ready}, 32'd0);
      chk("mv_n1", {20'd0, bus.disp_move_command}, 32'd0);
      tick();
      chk("mv_n2", {20'd0, bus.disp_move_command}, 32'h800);
      chk("mv_blank_readys", {29'd0, bus.loc_ready, bus.orient_ready, bus.move_ready}, 32'd7);
      chk("mv_quals", {29'd0, bus.new_data, bus.orientation_ready, bus.stale}, 32'b000);
      vsync = 1'b1;
      tick();

      // Orientation alone, then empty frames drive the stale counter.
      bus.orient_valid = 1'b1; bus.orient_data = 4'h9;
      tick();
      clear_valids();
      frame();
      chk("or_only_quals", {29'd0, bus.new_data, bus.orientation_ready, bus.stale}, 32'b010);
      chk("or_only_orient", {28'd0, bus.disp_orientation}, 32'h9);
      frame();
      chk("stale_set", {29'd0, bus.new_data, bus.orientation_ready, bus.stale}, 32'b011);
      frame();
      chk("stale_sat", {31'd0, bus.stale}, 32'd1);
      bus.loc_valid = 1'b1; bus.loc_data = 12'h3C3;
      tick();
      clear_valids();
      frame();
      chk("stale_clr_quals", {29'd0, bus.new_data, bus.orientation_ready, bus.stale}, 32'b100);
      chk("stale_clr_loc", {20'd0, bus.disp_location}, 32'h3C3);

      // Reset mid-operation discards pending data.
      bus.loc_valid = 1'b1; bus.loc_data = 12'h555;
      tick();
      bus.loc_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_loc", {20'd0, bus.disp_location}, 32'd0);
      chk("mid_rst_quals", {29'd0, bus.new_data, bus.orientation_ready, bus.stale}, 32'd0);
      frame();
      chk("mid_rst_discard", {20'd0, bus.disp_location}, 32'd0);
      chk("mid_rst_new", {31'd0, bus.new_data}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
